// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the pipeline and a word-wide memory bus.
//
// Takes one byte/halfword/word access at a time, at any byte alignment.
// Accesses that straddle a word boundary become two bus beats, and the
// result is reassembled from both words. Each beat has its own watchdog.
// If the bus stalls too long, the access ends with an error response.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      pipeline request handshake (ready only in IDLE)
//   req_we, req_type         store flag, access type (lb/lh/lw/lbu/lhu)
//   req_addr, req_wdata      byte address, right-justified store data
//   resp_valid/err/rdata     one-cycle completion pulse with extended data
//   mem_req/mem_gnt          bus request, accepted when mem_gnt=1
//   mem_we/be/addr/wdata     beat write flag, byte lanes, word address, data
//   mem_rvalid/mem_rdata     beat completion, word read data
// ---------------------------------------------------------------------------
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // The watchdog fires on the cycle whose count reaches TIMEOUT.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  // Loads accept only the five defined encodings. Stores use only the size
  // bits, so only size 11 is illegal for a store.
  function automatic logic legal_type(input logic we, input logic [2:0] t);
    if (we) return (t[1:0] != 2'b11);
    return (t == 3'b000) || (t == 3'b001) || (t == 3'b010) ||
           (t == 3'b100) || (t == 3'b101);
  endfunction

  // Byte-lane mask shifted across two words. The low nibble holds the
  // lanes of the first beat and the high nibble the lanes of the second.
  function automatic logic [7:0] be_span(input logic [1:0] sz,
                                         input logic [1:0] off);
    logic [3:0] mask;
    case (sz)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    return {4'b0000, mask} << off;
  endfunction

  // Store data shifted into lanes across two words.
  function automatic logic [63:0] wdata_span(input logic [31:0] wd,
                                             input logic [1:0]  off);
    return {32'd0, wd} << {off, 3'b000};
  endfunction

  // Pull the addressed bytes out of {hi,lo} and extend them to 32 bits.
  function automatic logic [31:0] load_ext(input logic [63:0] words,
                                           input logic [1:0]  off,
                                           input logic [2:0]  t);
    logic [31:0] sh;
    sh = 32'(words >> {off, 3'b000});
    case (t[1:0])
      2'b00:   return t[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return t[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  type_q, type_d;
  logic        we_q, we_d;
  logic [31:0] lo_q, lo_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] src_addr;
  logic [31:0] src_wdata;
  logic [2:0]  src_type;
  logic [7:0]  span_be;
  logic [63:0] span_wd;
  logic        split;
  logic        timeout_hit;

  // Next-state and next-output logic. Every output is registered, so each
  // output value is computed here for the state being entered. In IDLE the
  // first beat is built straight from the request inputs. The request is
  // captured on the same edge, so the captured copy is not ready yet.
  always_comb begin
    src_addr    = (state_q == IDLE) ? req_addr  : addr_q;
    src_wdata   = (state_q == IDLE) ? req_wdata : wdata_q;
    src_type    = (state_q == IDLE) ? req_type  : type_q;
    span_be     = be_span(src_type[1:0], src_addr[1:0]);
    span_wd     = wdata_span(src_wdata, src_addr[1:0]);
    split       = |span_be[7:4];
    timeout_hit = (cnt_q == TO_LAST);

    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    type_d       = type_q;
    we_d         = we_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          type_d  = req_type;
          we_d    = req_we;
          if (!legal_type(req_we, req_type)) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = REQ0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = span_be[3:0];
            mem_wdata_d = span_wd[31:0];
            cnt_d       = 16'd0;
          end
        end
      end

      REQ0, REQ1: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_gnt) begin
          state_d = (state_q == REQ0) ? WAIT0 : WAIT1;
        end else if (timeout_hit) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      WAIT0: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          lo_d = mem_rdata;
          if (split) begin
            state_d     = REQ1;
            mem_req_d   = 1'b1;
            mem_we_d    = we_q;
            mem_addr_d  = {addr_q[31:2], 2'b00} + 32'd4;
            mem_be_d    = span_be[7:4];
            mem_wdata_d = span_wd[63:32];
            cnt_d       = 16'd0;
          end else begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_rdata_d = we_q ? 32'd0
                                : load_ext({32'd0, mem_rdata}, addr_q[1:0], type_q);
          end
        end else if (timeout_hit) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end

      WAIT1: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'd0
                              : load_ext({mem_rdata, lo_q}, addr_q[1:0], type_q);
        end else if (timeout_hit) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State register and registered outputs. Reset returns to IDLE and
  // abandons any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      type_q       <= 3'd0;
      we_q         <= 1'b0;
      lo_q         <= 32'd0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      type_q       <= type_d;
      we_q         <= we_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- directed testbench for lsu (built with TIMEOUT=4).
// A simple bus responder grants on the first request cycle and completes
// the beat on the following cycle. Either of these can be withheld to
// force a timeout.
// ---------------------------------------------------------------------------
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  int          obs_beats, obs_req_cycles, obs_lat;
  logic [31:0] obs_addr[2];
  logic [31:0] obs_wdata[2];
  logic [3:0]  obs_be[2];
  logic        obs_we[2];
  logic [31:0] obs_rdata;
  logic        obs_err;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, act as the bus, and record every beat and the
  // response. obs_lat is the cycle after acceptance on which resp_valid
  // appears. It is 0 if no response arrives within the budget.
  task automatic run_access(input logic we, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input logic give_gnt, input logic give_rvalid);
    logic prev_req;
    logic pend;
    obs_beats = 0; obs_req_cycles = 0; obs_lat = 0;
    obs_rdata = '0; obs_err = 1'b0; prev_req = 1'b0; pend = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs_addr[i] = '0; obs_wdata[i] = '0; obs_be[i] = '0; obs_we[i] = 1'b0;
    end
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL accept_ready got=%b exp=1", req_ready);
    end
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (resp_valid === 1'b1) begin
        obs_lat = k; obs_rdata = resp_rdata; obs_err = resp_err;
        break;
      end
      if (pend) begin
        mem_rvalid = give_rvalid;
        mem_rdata  = (obs_beats == 1) ? rd0 : rd1;
        pend = 1'b0;
      end
      if (mem_req === 1'b1) begin
        obs_req_cycles++;
        if (!prev_req && obs_beats < 2) begin
          obs_addr[obs_beats]  = mem_addr;
          obs_be[obs_beats]    = mem_be;
          obs_wdata[obs_beats] = mem_wdata;
          obs_we[obs_beats]    = mem_we;
          obs_beats++;
        end
        if (give_gnt) begin
          mem_gnt = 1'b1;
          pend = 1'b1;
        end
      end
      prev_req = (mem_req === 1'b1);
      step();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be} !== 9'b1_0000_0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=100000000",
               {req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be});
    end
    checks++;
    if ({mem_addr, mem_wdata, resp_rdata} !== 96'd0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h/%h/%h exp=0", mem_addr, mem_wdata, resp_rdata);
    end
  endtask

  task automatic test_lw();
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_beats !== 1 || obs_addr[0] !== 32'h100 || obs_be[0] !== 4'b1111 || obs_we[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lw_beat got=%0d/%h/%b/%b exp=1/00000100/1111/0",
               obs_beats, obs_addr[0], obs_be[0], obs_we[0]);
    end
    checks++;
    if (obs_lat !== 3) begin
      failures++;
      $display("[TB] FAIL lw_latency got=%0d exp=3", obs_lat);
    end
    checks++;
    if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lw_rdata got=%h err=%b exp=deadbeef err=0", obs_rdata, obs_err);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lw_pulse got=%b/%b exp=0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_byte_half();
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_rdata !== 32'hFFFFFF80 || obs_be[0] !== 4'b1000 || obs_lat !== 3) begin
      failures++;
      $display("[TB] FAIL lb_sext got=%h/%b/%0d exp=ffffff80/1000/3", obs_rdata, obs_be[0], obs_lat);
    end
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_rdata !== 32'h00000080) begin
      failures++;
      $display("[TB] FAIL lbu_zext got=%h exp=00000080", obs_rdata);
    end
    run_access(1'b0, 3'b101, 32'h2, 32'h0, 32'hBEEF1234, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_rdata !== 32'h0000BEEF || obs_be[0] !== 4'b1100 || obs_beats !== 1) begin
      failures++;
      $display("[TB] FAIL lhu got=%h/%b/%0d exp=0000beef/1100/1", obs_rdata, obs_be[0], obs_beats);
    end
    run_access(1'b1, 3'b000, 32'h1, 32'h123456A5, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_be[0] !== 4'b0010 || obs_wdata[0] !== 32'h3456A500 || obs_we[0] !== 1'b1 || obs_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL sb got=%b/%h/%b/%h exp=0010/3456a500/1/0",
               obs_be[0], obs_wdata[0], obs_we[0], obs_rdata);
    end
    run_access(1'b1, 3'b110, 32'h40, 32'hA1B2C3D4, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_be[0] !== 4'b1111 || obs_wdata[0] !== 32'hA1B2C3D4 || obs_err !== 1'b0 || obs_lat !== 3) begin
      failures++;
      $display("[TB] FAIL sw_type110 got=%b/%h/%b/%0d exp=1111/a1b2c3d4/0/3",
               obs_be[0], obs_wdata[0], obs_err, obs_lat);
    end
  endtask

  task automatic test_split();
    run_access(1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_beats !== 2 || obs_addr[0] !== 32'h100 || obs_be[0] !== 4'b1100 || obs_wdata[0] !== 32'h33440000) begin
      failures++;
      $display("[TB] FAIL sw_beat0 got=%0d/%h/%b/%h exp=2/00000100/1100/33440000",
               obs_beats, obs_addr[0], obs_be[0], obs_wdata[0]);
    end
    checks++;
    if (obs_addr[1] !== 32'h104 || obs_be[1] !== 4'b0011 || obs_wdata[1] !== 32'h00001122 || obs_we[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sw_beat1 got=%h/%b/%h/%b exp=00000104/0011/00001122/1",
               obs_addr[1], obs_be[1], obs_wdata[1], obs_we[1]);
    end
    checks++;
    if (obs_lat !== 5 || obs_rdata !== 32'h0 || obs_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sw_resp got=%0d/%h/%b exp=5/0/0", obs_lat, obs_rdata, obs_err);
    end
    run_access(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);
    checks++;
    if (obs_addr[0] !== 32'hFFFFFFFC || obs_addr[1] !== 32'h0 || obs_be[0] !== 4'b1000 || obs_be[1] !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL lh_wrap_beats got=%h/%h/%b/%b exp=fffffffc/00000000/1000/0001",
               obs_addr[0], obs_addr[1], obs_be[0], obs_be[1]);
    end
    checks++;
    if (obs_rdata !== 32'hFFFFF012 || obs_lat !== 5) begin
      failures++;
      $display("[TB] FAIL lh_wrap_data got=%h/%0d exp=fffff012/5", obs_rdata, obs_lat);
    end
  endtask

  task automatic test_illegal();
    run_access(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_lat !== 1 || obs_err !== 1'b1 || obs_beats !== 0 || obs_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL illegal_load got=%0d/%b/%0d/%h exp=1/1/0/0", obs_lat, obs_err, obs_beats, obs_rdata);
    end
    run_access(1'b1, 3'b111, 32'h10, 32'h55, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_lat !== 1 || obs_err !== 1'b1 || obs_beats !== 0) begin
      failures++;
      $display("[TB] FAIL illegal_store got=%0d/%b/%0d exp=1/1/0", obs_lat, obs_err, obs_beats);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obs_req_cycles !== 4 || obs_lat !== 5) begin
      failures++;
      $display("[TB] FAIL timeout_req got=%0d/%0d exp=4/5", obs_req_cycles, obs_lat);
    end
    checks++;
    if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL timeout_resp got=%b/%h exp=1/0", obs_err, obs_rdata);
    end
    run_access(1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (obs_beats !== 1 || obs_err !== 1'b1 || obs_lat !== 5) begin
      failures++;
      $display("[TB] FAIL timeout_split got=%0d/%b/%0d exp=1/1/5", obs_beats, obs_err, obs_lat);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'b010; req_addr = 32'h300; req_wdata = 32'h0;
    step();
    req_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_req got=%b exp=1", mem_req);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_idle got=%b/%b/%b exp=1/0/0", req_ready, resp_valid, mem_req);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      mem_rvalid = 1'b0;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_noresp got=%b exp=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 32'h0, 1'b1, 1'b1);
    run_access(1'b0, 3'b001, 32'h106, 32'h0, 32'h7FFE0000, 32'h0, 1'b1, 1'b1);
    checks++;
    if (obs_rdata !== 32'h00007FFE || obs_addr[0] !== 32'h104 || obs_be[0] !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL b2b_second got=%h/%h/%b exp=00007ffe/00000104/1100",
               obs_rdata, obs_addr[0], obs_be[0]);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_lw();
    test_byte_half();
    test_split();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles one bus beat may spend in REQ or WAIT before abort (range 1..65535).
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: req_valid  in  1  pipeline access request.
REQ-005 Port: req_ready  out  1  LSU can accept a request.
REQ-006 Port: req_we  in  1  1 = store, 0 = load.
REQ-007 Port: req_type  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for stores, only bits[1:0] select size.
REQ-008 Port: req_addr  in  32  byte address, any alignment.
REQ-009 Port: req_wdata  in  32  store data, right-justified.
REQ-010 Port: resp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 Port: resp_err  out  1  valid with resp_valid; illegal type or timeout.
REQ-013 Port: mem_req  out  1  bus request.
REQ-014 Port: mem_gnt  in  1  bus accepts the request this cycle.
REQ-015 Port: mem_we / mem_be / mem_addr / mem_wdata  out  1/4/32/32  beat write flag, byte enables, word-aligned address, lane-aligned data.
REQ-016 Port: mem_rvalid / mem_rdata  in  1/32  beat completion for loads and stores; word read data.

Function
REQ-017 FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE; req_ready=1 only in IDLE.
REQ-018 IDLE, req_valid=1 captures all req_* fields.
- Illegal types (011, 110, 111 loads; size 11 stores) go to DONE with resp_err=1.
- All other types go to REQ0.
REQ-019 Size n=1/2/4 bytes, off=addr[1:0], mask=(1<<n)-1; split=1 when off+n>4.
REQ-020 REQ0 drives the following; all fields stay stable until a cycle with mem_gnt=1, then the FSM goes to WAIT0.
- mem_req=1
- mem_addr={addr[31:2],2'b00}
- mem_be=(mask<<off)[3:0]
- mem_wdata=wdata<<(8*off)
- mem_we=req_we
REQ-021 WAIT0 holds mem_req=0; on mem_rvalid it stores mem_rdata as lo, then goes to REQ1 if split, else DONE.
REQ-022 REQ1 drives the following; same gnt rule as REQ0, then WAIT1.
- mem_addr=base+4, wrapping modulo 2^32
- mem_be=mask>>(4-off)
- mem_wdata=wdata>>(8*(4-off))
REQ-023 WAIT1: on mem_rvalid, store hi and go to DONE.
REQ-024 DONE asserts resp_valid=1 for exactly one cycle, then returns to IDLE.
- Load data: bytes of {hi,lo}>>(8*off), low n bytes.
- Sign-extend for 000/001; zero-extend for 100/101.
REQ-025 mem_gnt and mem_rvalid are ignored in states that do not wait for them.
- mem_rvalid in the same cycle as mem_gnt is not counted.
REQ-026 Timeout counter: cleared on each REQx entry, increments each cycle in REQx/WAITx.
- On reaching TIMEOUT: drop mem_req, go to DONE with resp_err=1, resp_rdata=0.
- The second beat of a split store is not issued after a first-beat timeout.
REQ-027 Latency with mem_gnt=1 on the first REQ cycle and mem_rvalid the next cycle:
- Aligned access: resp_valid 3 cycles after acceptance.
- Split access: resp_valid 5 cycles after acceptance.
- Illegal type: resp_valid 1 cycle after acceptance.
REQ-028 req_valid outside IDLE is ignored; the requester holds the request until req_ready=1.

Reset
REQ-029 rst=1 at a rising edge forces IDLE and clears captured fields and the timeout counter.
- Outputs next cycle: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-transaction abandons the beat with no response.
- A late mem_rvalid after reset is ignored.

Verification
REQ-031 lw at 0x100, mem_rdata=0xDEADBEEF -> one beat with mem_addr=0x100, be=1111; resp_rdata=0xDEADBEEF 3 cycles after accept.
REQ-032 lb at 0x103, rdata=0x80xxxxxx -> resp_rdata=0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-033 sw 0x11223344 at 0x102 -> two beats:
- Beat 1: addr 0x100, be=1100, wdata=0x33440000.
- Beat 2: addr 0x104, be=0011, wdata=0x00001122.
- resp_valid at cycle 5.
REQ-034 lh at 0xFFFFFFFF -> beat addresses 0xFFFFFFFC then 0x00000000; result {lo[31:24]=LSB, hi[7:0]=MSB} sign-extended.
REQ-035 TIMEOUT=4 with mem_gnt held 0 -> mem_req drops after 4 cycles; resp_err=1, resp_rdata=0.
- req_type=011 -> resp_err=1 one cycle after accept, with no mem_req.
REQ-036 rst pulsed while in WAIT0, then mem_rvalid arrives -> no resp_valid; req_ready=1 the cycle after reset.
